// File: rtl/arb_req_queue.sv
// arb_req_queue: per-channel request FIFOs feeding a two-requester arbiter, with a registered pop port.
// Optional macro ARB_REQ_QUEUE_STATS_EN adds per-channel pop counters (gcnt0/gcnt1) and a starve flag.
module arb_req_queue_ch #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             req,
  output logic             full,
  output logic             ovf,
  output logic [WIDTH-1:0] head
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      cnt;
  logic             wr_en;

  assign req  = (cnt != '0);
  assign full = (cnt == (AW+1)'(DEPTH));
  assign head = mem[rd_ptr];
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign wr_en = push && (!full || pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      if (wr_en && !pop)      cnt <= cnt + (AW+1)'(1);
      else if (pop && !wr_en) cnt <= cnt - (AW+1)'(1);
      if (push && !wr_en) ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end
endmodule

module arb_req_queue #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push0,
  input  logic [WIDTH-1:0] din0,
  input  logic             push1,
  input  logic [WIDTH-1:0] din1,
  output logic             full0,
  output logic             full1,
  output logic             req0,
  output logic             req1,
  input  logic             gnt0,
  input  logic             gnt1,
  output logic             out_valid,
  output logic             out_ch,
  output logic [WIDTH-1:0] out_data,
  output logic             ovf0,
  output logic             ovf1,
`ifdef ARB_REQ_QUEUE_STATS_EN
  output logic [15:0]      gcnt0,
  output logic [15:0]      gcnt1,
  output logic             starve,
`endif
  output logic             err
);
  localparam int NUM_LANES = 2;

  logic [NUM_LANES-1:0]            push, gnt, req, full, ovf, pop;
  logic [NUM_LANES-1:0][WIDTH-1:0] din, head;
  logic                            viol;

  assign push  = {push1, push0};
  assign gnt   = {gnt1, gnt0};
  assign din   = {din1, din0};
  assign req0  = req[0];
  assign req1  = req[1];
  assign full0 = full[0];
  assign full1 = full[1];
  assign ovf0  = ovf[0];
  assign ovf1  = ovf[1];

  // A grant only pops when it is exclusive and lands on a non-empty channel.
  assign pop[0] = gnt[0] && req[0] && !gnt[1];
  assign pop[1] = gnt[1] && req[1] && !gnt[0];
  assign viol   = (gnt[0] && gnt[1]) || (gnt[0] && !req[0]) || (gnt[1] && !req[1]);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_ch
    arb_req_queue_ch #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_ch (
      .clk  (clk),
      .reset(reset),
      .push (push[i]),
      .pop  (pop[i]),
      .din  (din[i]),
      .req  (req[i]),
      .full (full[i]),
      .ovf  (ovf[i]),
      .head (head[i])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_ch    <= 1'b0;
      out_data  <= '0;
      err       <= 1'b0;
    end else begin
      out_valid <= |pop;
      if (|pop) begin
        out_ch   <= pop[1];
        out_data <= pop[1] ? head[1] : head[0];
      end
      if (viol) err <= 1'b1;
    end
  end

`ifdef ARB_REQ_QUEUE_STATS_EN
  logic [NUM_LANES-1:0][15:0] gcnt;
  logic [NUM_LANES-1:0][3:0]  wait_cnt;

  assign gcnt0 = gcnt[0];
  assign gcnt1 = gcnt[1];

  // wait_cnt tracks consecutive requesting cycles without a pop; the 16th such cycle flags starve.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gcnt     <= '0;
      wait_cnt <= '0;
      starve   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (pop[i] && gcnt[i] != 16'hFFFF) gcnt[i] <= gcnt[i] + 16'd1;
        if (!req[i] || pop[i])        wait_cnt[i] <= '0;
        else if (wait_cnt[i] == 4'hF) starve      <= 1'b1;
        else                          wait_cnt[i] <= wait_cnt[i] + 4'd1;
      end
    end
  end
`endif
endmodule

// File: doc/arb_req_queue.md
Name: arb_req_queue

Overview:
- Request front-end placed directly upstream of the two-requester arbiter.
- Buffers transactions from two sources in per-channel FIFOs and drives the arbiter's req0/req1 lines.
- Consumes gnt0/gnt1 to pop the granted head entry and presents it on a single registered output port tagged with its channel.
- Flags overflow and grant-protocol violations for the checker and scoreboard.

Parameters:
WIDTH, 8, payload bits per entry
DEPTH, 4, entries per channel FIFO (power of two, >=2)
AW, 2, pointer width = log2(DEPTH)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
push0  input  1  write strobe, channel 0
din0  input  WIDTH  payload, channel 0
push1  input  1  write strobe, channel 1
din1  input  WIDTH  payload, channel 1
full0  output  1  channel 0 FIFO holds DEPTH entries
full1  output  1  channel 1 FIFO holds DEPTH entries
req0  output  1  request to arbiter, channel 0
req1  output  1  request to arbiter, channel 1
gnt0  input  1  grant from arbiter, channel 0
gnt1  input  1  grant from arbiter, channel 1
out_valid  output  1  out_data/out_ch valid this cycle
out_ch  output  1  channel of popped entry
out_data  output  WIDTH  popped payload
ovf0  output  1  sticky: push to full channel 0 dropped
ovf1  output  1  sticky: push to full channel 1 dropped
err  output  1  sticky: grant protocol violation

Behaviour:
- Reset (reset=0, asynchronous):
  - pointers and counts cleared to 0.
  - req0, req1, full0, full1, out_valid, out_ch, out_data, ovf0, ovf1 and err all 0.
  - FIFO storage contents are don't-care.
  - Reset asserted mid-operation discards all queued entries immediately; no out_valid pulse on release.
- Per channel n: wr_ptr, rd_ptr (AW bits, wrap modulo DEPTH) and cnt (AW+1 bits, 0..DEPTH), all registered.
  - reqn = (cnt != 0); fulln = (cnt == DEPTH). Both decode directly from the registered cnt.
- Pop: a valid pop on channel n occurs on a rising clk edge when gntn=1, reqn=1 and the other grant is 0.
  - Effects: rd_ptr+1, cnt-1.
  - Next cycle: out_valid=1, out_ch=n, out_data=head entry. Latency is 1 clock from grant sample to output.
- Push: pushn=1 writes dinn at wr_ptr, then wr_ptr+1 and cnt+1.
  - Push when cnt==DEPTH with no pop on the same channel: dropped, ovfn set to 1 (sticky until reset), cnt unchanged.
  - Push and pop on the same channel in the same cycle: both performed, cnt unchanged. This holds even when full (the slot freed by the pop is reused); when cnt==1 the popped entry is the old head, not the new data.
- Grant violations (set err, sticky until reset; no pop):
  - gnt0=1 and gnt1=1 in the same cycle.
  - gntn=1 while reqn=0 (grant to an empty channel).
- out_valid is 0 in any cycle not following a valid pop. out_data and out_ch hold their last values when out_valid=0.
- Consecutive cycles of gntn=1 with reqn=1 pop one entry per cycle. reqn falls on the edge that pops the last entry.
- Pointer wrap: DEPTH-1 -> 0 with no bubble. FIFO order is strict per channel.
- Channels are fully independent apart from the shared output port.

Optional Feature:
Macro ARB_REQ_QUEUE_STATS_EN.
- Defined:
  - adds outputs gcnt0 and gcnt1 (16 bits each), counting valid pops per channel. Both saturate at 16'hFFFF and reset to 0.
  - adds output starve (1 bit): set sticky when a channel keeps reqn=1 for 16 consecutive cycles without a valid pop.
- Not defined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Reset then idle -> all outputs 0; pulse reset low mid-queue with 3 entries in ch0 -> req0=0, full0=0 immediately; after release, out_valid stays 0.
- Push ch0 data 8'h11, 8'h22; hold gnt0=1 for 2 cycles -> out_valid 1 for 2 cycles, out_ch=0, out_data 8'h11 then 8'h22; req0 falls on the 2nd grant edge.
- Push 5 values 8'hA0..8'hA4 into ch1 with no grants -> full1=1 after the 4th push, 5th push dropped, ovf1=1; draining yields A0..A3 only.
- Ch0 full (8'h01..8'h04); push 8'h05 with gnt0=1 in the same cycle -> out_data 8'h01, full0 stays 1, ovf0 stays 0; later drain yields 02,03,04,05.
- gnt0=gnt1=1 with both channels non-empty -> err=1, no out_valid, counts unchanged; separately, gnt1=1 with ch1 empty -> err=1.
- Alternating grants, 100 random pushes per channel with wrap-around -> per-channel output order matches push order, no loss while ovf0=ovf1=0.
